// File: rtl/rtc_set_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rtc_set_sequencer: RTC time-set flow (bus load, BCD edit, commit)  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rtc_set_sequencer #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int NFIELDS       = 9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       edit_i,
  input  logic       next_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       cancel_i,
  input  logic       tick_i,
  output logic       bus_req_o,
  output logic       bus_we_o,
  output logic [3:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  input  logic [7:0] bus_rdata_i,
  input  logic       bus_ack_i,
  output logic [3:0] field_o,
  output logic [7:0] value_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int         c_cnt_w = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [3:0] c_last  = 4'(NFIELDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EDIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_shadow     [NFIELDS];
  logic [7:0]          w_shadow_nxt [NFIELDS];
  logic [3:0]          r_field, w_field_nxt;
  logic [c_cnt_w-1:0]  r_tick_cnt, w_tick_cnt_nxt;
  logic                r_req, w_req_nxt;
  logic                r_we, w_we_nxt;
  logic [3:0]          r_addr, w_addr_nxt;
  logic [7:0]          r_wdata, w_wdata_nxt;
  logic                r_done, w_done_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [3:0]          r_field_o, w_field_o_nxt;
  logic [7:0]          r_value_o, w_value_o_nxt;
  logic                r_busy, w_busy_nxt;
  logic [3:0]          w_aidx, w_fidx, w_nidx;

  function automatic logic [7:0] f_min(input logic [3:0] f);
    return (f == 4'd4 || f == 4'd5) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] f_max(input logic [3:0] f);
    case (f)
      4'd3, 4'd7: return 8'h23;
      4'd4:       return 8'h31;
      4'd5:       return 8'h12;
      4'd6:       return 8'h99;
      default:    return 8'h59;
    endcase
  endfunction

  // Non-BCD or out-of-range reads fall back to the field minimum.
  function automatic logic [7:0] f_sanitize(input logic [3:0] f, input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < f_min(f) || v > f_max(f))
      return f_min(f);
    return v;
  endfunction

  function automatic logic [7:0] f_inc(input logic [3:0] f, input logic [7:0] v);
    if (v == f_max(f))     return f_min(f);
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] f_dec(input logic [3:0] f, input logic [7:0] v);
    if (v == f_min(f))     return f_max(f);
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_field_nxt    = r_field;
    w_tick_cnt_nxt = r_tick_cnt;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_aidx         = r_addr - 4'd1;
    w_fidx         = r_field - 4'd1;
    for (int i = 0; i < NFIELDS; i++) w_shadow_nxt[i] = r_shadow[i];

    case (r_state)
      ST_IDLE: begin
        if (edit_i) begin
          w_state_nxt = ST_LOAD;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = 4'd1;
        end
      end
      ST_LOAD: begin
        if (r_req && bus_ack_i) begin
          w_shadow_nxt[w_aidx] = f_sanitize(r_addr, bus_rdata_i);
          w_req_nxt            = 1'b0;
          if (r_addr == c_last) begin
            w_state_nxt    = ST_EDIT;
            w_field_nxt    = 4'd1;
            w_tick_cnt_nxt = '0;
            w_addr_nxt     = 4'd0;
          end else begin
            w_addr_nxt = r_addr + 4'd1;
          end
        end else if (!r_req) begin
          w_req_nxt = 1'b1;
        end
      end
      ST_EDIT: begin
        if (cancel_i) begin
          w_state_nxt = ST_IDLE;
        end else if (edit_i) begin
          w_state_nxt = ST_COMMIT;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = 4'd1;
          w_wdata_nxt = r_shadow[0];
        end else if (next_i) begin
          w_field_nxt    = (r_field == c_last) ? 4'd1 : r_field + 4'd1;
          w_tick_cnt_nxt = '0;
        end else if (inc_i || dec_i) begin
          w_tick_cnt_nxt = '0;
          if (inc_i != dec_i)
            w_shadow_nxt[w_fidx] = inc_i ? f_inc(r_field, r_shadow[w_fidx])
                                         : f_dec(r_field, r_shadow[w_fidx]);
        end else if (tick_i) begin
          if (r_tick_cnt == c_cnt_w'(TIMEOUT_TICKS - 1)) begin
            w_state_nxt    = ST_IDLE;
            w_timeout_nxt  = 1'b1;
            w_tick_cnt_nxt = '0;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (r_req && bus_ack_i) begin
          w_req_nxt = 1'b0;
          if (r_addr == c_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = 4'd0;
            w_wdata_nxt = 8'h00;
          end else begin
            w_addr_nxt = r_addr + 4'd1;
          end
        end else if (!r_req) begin
          // Address was advanced on the ack edge, so it already names the next field.
          w_req_nxt   = 1'b1;
          w_wdata_nxt = r_shadow[w_aidx];
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_nidx        = w_field_nxt - 4'd1;
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_field_o_nxt = (w_state_nxt == ST_EDIT) ? w_field_nxt : 4'd0;
    w_value_o_nxt = (w_state_nxt == ST_EDIT) ? w_shadow_nxt[w_nidx] : 8'h00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_field    <= 4'd0;
      r_tick_cnt <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 4'd0;
      r_wdata    <= 8'h00;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_field_o  <= 4'd0;
      r_value_o  <= 8'h00;
      r_busy     <= 1'b0;
      for (int i = 0; i < NFIELDS; i++) r_shadow[i] <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_field    <= w_field_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
      r_field_o  <= w_field_o_nxt;
      r_value_o  <= w_value_o_nxt;
      r_busy     <= w_busy_nxt;
      for (int i = 0; i < NFIELDS; i++) r_shadow[i] <= w_shadow_nxt[i];
    end
  end

  assign bus_req_o   = r_req;
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign field_o     = r_field_o;
  assign value_o     = r_value_o;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rtc_set_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rtc_set_sequencer: directed bench with bus slave and scoreboard |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rtc_set_sequencer;

  logic       clk_i, rst_i;
  logic       edit_i, next_i, inc_i, dec_i, cancel_i, tick_i;
  logic       bus_req_o, bus_we_o;
  logic [3:0] bus_addr_o;
  logic [7:0] bus_wdata_o, bus_rdata_i;
  logic       bus_ack_i;
  logic [3:0] field_o;
  logic [7:0] value_o;
  logic       busy_o, done_o, timeout_o;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } tx_t;

  tx_t        exp_q[$];
  logic [7:0] rd_mem [1:9];
  logic [3:0] stall_addr;
  int         checks = 0;
  int         errors = 0;

  rtc_set_sequencer #(.TIMEOUT_TICKS(3), .NFIELDS(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .edit_i(edit_i), .next_i(next_i), .inc_i(inc_i), .dec_i(dec_i),
    .cancel_i(cancel_i), .tick_i(tick_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .field_o(field_o), .value_o(value_o), .busy_o(busy_o),
    .done_o(done_o), .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [71:0] v);
    for (int i = 1; i <= 9; i++) rd_mem[i] = v[71-8*(i-1) -: 8];
  endtask

  task automatic push_reads();
    for (int i = 1; i <= 9; i++) exp_q.push_back('{we: 1'b0, addr: 4'(i), data: rd_mem[i]});
  endtask

  task automatic push_writes(input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back('{we: 1'b1, addr: 4'(i), data: rd_mem[i]});
  endtask

  task automatic press(input logic e, input logic n, input logic i,
                       input logic d, input logic c, input logic t);
    @(negedge clk_i);
    edit_i = e; next_i = n; inc_i = i; dec_i = d; cancel_i = c; tick_i = t;
    @(negedge clk_i);
    edit_i = 0; next_i = 0; inc_i = 0; dec_i = 0; cancel_i = 0; tick_i = 0;
  endtask

  task automatic wait_edit(input string tag);
    int n = 0;
    while (!(busy_o && field_o == 4'd1) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, {busy_o, field_o}, {1'b1, 4'd1});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, done_o, 1'b1);
  endtask

  // Bus slave: acks 1-3 cycles late, never acks stall_addr, and retires each
  // completed transaction against the scoreboard.
  initial begin : slave
    logic [3:0] a;
    logic       w;
    logic [7:0] d;
    int         dly, waited;
    bit         abandoned, expect_req;
    tx_t        e;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 8'h00;
    expect_req  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (expect_req) begin
        chk("req_regrant", bus_req_o, 1'b1);
        expect_req = 1'b0;
      end
      if (bus_req_o) begin
        a = bus_addr_o; w = bus_we_o; d = bus_wdata_o;
        dly = int'($urandom_range(3, 1));
        waited = 0;
        abandoned = 1'b0;
        while (!abandoned && (waited < dly || a == stall_addr)) begin
          @(negedge clk_i);
          waited++;
          if (!bus_req_o) abandoned = 1'b1;
          else chk("bus_hold", {bus_we_o, bus_addr_o, bus_wdata_o}, {w, a, d});
        end
        if (!abandoned) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = w ? 8'h00 : rd_mem[a];
          @(negedge clk_i);
          bus_ack_i   = 1'b0;
          bus_rdata_i = 8'h00;
          chk("gap_req_low", bus_req_o, 1'b0);
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_tx: observed we=%0d addr=%0d, expected no transaction", w, a);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_we", w, e.we);
            chk("tx_addr", a, e.addr);
            if (w) chk("tx_wdata", d, e.data);
          end
          expect_req = (a != 4'd9);
        end
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    edit_i = 0; next_i = 0; inc_i = 0; dec_i = 0; cancel_i = 0; tick_i = 0;
    stall_addr = 4'd0;
    set_mem(72'h0);
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, field_o,
                          value_o, busy_o, done_o, timeout_o}, 32'h0);
    rst_i = 1'b0;

    // Load/commit round trip
    set_mem(72'h45_30_12_15_06_16_00_00_00);
    push_reads();
    press(1, 0, 0, 0, 0, 0);
    wait_edit("rt_enter_edit");
    chk("rt_value_f1", value_o, 8'h45);
    chk("rt_reads_done", exp_q.size(), 0);
    push_writes(9);
    press(1, 0, 0, 0, 0, 0);
    wait_done("rt_done_pulse");
    @(negedge clk_i);
    chk("rt_done_single", {done_o, busy_o}, 2'b00);
    chk("rt_writes_done", exp_q.size(), 0);

    // Wrap boundaries and simultaneous buttons
    set_mem(72'h09_30_23_01_12_00_05_00_00);
    push_reads();
    press(1, 0, 0, 0, 0, 0);
    wait_edit("wr_enter_edit");
    press(0, 0, 1, 0, 0, 0);
    chk("sec_09_inc", value_o, 8'h10);
    press(0, 1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0, 0);
    chk("hour_field", {field_o, value_o}, {4'd3, 8'h23});
    press(0, 0, 1, 0, 0, 0);
    chk("hour_23_inc", value_o, 8'h00);
    press(0, 1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0, 0);
    chk("day_01_dec", {field_o, value_o}, {4'd4, 8'h31});
    press(0, 1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0, 0);
    chk("month_12_inc", {field_o, value_o}, {4'd5, 8'h01});
    press(0, 1, 1, 0, 0, 0);
    chk("next_inc_same", {field_o, value_o}, {4'd6, 8'h00});
    press(0, 0, 0, 1, 0, 0);
    chk("year_00_dec", value_o, 8'h99);
    press(0, 0, 1, 1, 0, 0);
    chk("inc_dec_same", value_o, 8'h99);
    press(1, 0, 0, 0, 1, 0);
    chk("cancel_edit_idle", {busy_o, field_o, value_o}, 13'h0);
    repeat (6) @(negedge clk_i);
    chk("cancel_no_tx", {exp_q.size() == 0, bus_req_o}, 2'b10);

    // Sanitizing on load, field wrap, timeout restart
    set_mem(72'h7A_59_24_15_00_16_23_59_59);
    push_reads();
    press(1, 0, 0, 0, 0, 0);
    wait_edit("sz_enter_edit");
    chk("sz_sec_7A", value_o, 8'h00);
    press(0, 1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0, 0);
    chk("sz_hour_24", {field_o, value_o}, {4'd3, 8'h00});
    press(0, 1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0, 0);
    chk("sz_month_00", {field_o, value_o}, {4'd5, 8'h01});
    repeat (4) press(0, 1, 0, 0, 0, 0);
    chk("sz_field9", {field_o, value_o}, {4'd9, 8'h59});
    press(0, 1, 0, 0, 0, 0);
    chk("next_wrap_f1", {field_o, value_o}, {4'd1, 8'h00});
    press(0, 0, 0, 0, 0, 1);
    press(0, 0, 0, 0, 0, 1);
    press(0, 0, 1, 0, 0, 0);
    chk("to_inc_value", value_o, 8'h01);
    press(0, 0, 0, 0, 0, 1);
    press(0, 0, 0, 0, 0, 1);
    chk("to_not_yet", {busy_o, timeout_o}, 2'b10);
    press(0, 0, 0, 0, 0, 1);
    chk("to_pulse", {timeout_o, busy_o, field_o, value_o}, {1'b1, 1'b0, 4'd0, 8'h00});
    @(negedge clk_i);
    chk("to_single", timeout_o, 1'b0);
    repeat (6) @(negedge clk_i);
    chk("to_no_tx", {exp_q.size() == 0, bus_req_o}, 2'b10);

    // Reset during the write to address 5
    set_mem(72'h45_30_12_15_06_16_00_00_00);
    push_reads();
    press(1, 0, 0, 0, 0, 0);
    wait_edit("rs_enter_edit");
    push_writes(4);
    stall_addr = 4'd5;
    press(1, 0, 0, 0, 0, 0);
    begin
      int n = 0;
      while (!(bus_req_o && bus_addr_o == 4'd5) && n < 300) begin
        @(negedge clk_i);
        n++;
      end
      chk("rs_reach_addr5", {bus_req_o, bus_addr_o}, {1'b1, 4'd5});
    end
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 chk("rs_async_clear", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, field_o,
                              value_o, busy_o, done_o, timeout_o}, 32'h0);
    @(negedge clk_i);
    stall_addr = 4'd0;
    rst_i = 1'b0;
    chk("rs_writes_1_4", exp_q.size(), 0);
    push_reads();
    press(1, 0, 0, 0, 0, 0);
    wait_edit("rs_reload");
    chk("rs_reload_value", value_o, 8'h45);
    chk("rs_reads_done", exp_q.size(), 0);
    press(0, 0, 0, 0, 1, 0);
    chk("rs_cancel", busy_o, 1'b0);

    repeat (4) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
